// File: rtl/fnn_stream_pkg.sv
// Shared types and defaults for the layer-to-layer neuron stream.
// Used by the result collector and the burst serializer.
package fnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int GAP_CYCLES = 4;
    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/result_collector.sv
// Gathers one result word per neuron, tracks which neurons have reported,
// and flags a sticky overrun when a neuron reports twice in one layer pass.
module result_collector
    import fnn_stream_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] neuron_out_i,
    input  logic [numNeurons-1:0]           neuron_valid_i,
    input  logic                            capture_i,
    input  logic                            clr_err_i,
    output logic [numNeurons*dataWidth-1:0] coll_o,
    output logic                            full_o,
    output logic                            overrun_o
);

    logic [numNeurons-1:0]           mask_q, mask_d;
    logic [numNeurons*dataWidth-1:0] coll_q;
    logic                            overrun_q, overrun_d;
    logic                            repeat_hit;

    // A strobe on the capture edge belongs to the next pass, so it is not a repeat;
    // strobes win over the capture clear so no result is dropped.
    always_comb begin
        repeat_hit = (|(mask_q & neuron_valid_i)) && !capture_i;
        mask_d     = (capture_i ? '0 : mask_q) | neuron_valid_i;
        overrun_d  = repeat_hit | (overrun_q & ~clr_err_i);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the data words are not reset; the mask guarantees none is read before it is written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeurons; i++) begin
            if (neuron_valid_i[i]) begin
                coll_q[i*dataWidth +: dataWidth] <= neuron_out_i[i*dataWidth +: dataWidth];
            end
        end
    end

    assign coll_o    = coll_q;
    assign full_o    = &mask_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/layer_out_serializer.sv
// Streams a complete layer's neuron results as one gap-free burst, then
// enforces a minimum idle gap before the next burst may start.
module layer_out_serializer
    import fnn_stream_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = DATA_WIDTH,
    parameter int gapCycles  = GAP_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    input  logic [numNeurons-1:0]           neuron_valid,
    input  logic                            clr_err,
    output logic [dataWidth-1:0]            data_out,
    output logic                            data_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int CW = $clog2(numNeurons + 1);
    localparam int GW = (gapCycles > 0) ? $clog2(gapCycles + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(numNeurons);
    localparam logic [GW-1:0] GAP_LAST = GW'((gapCycles > 0) ? gapCycles - 1 : 0);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [GW-1:0]                   gap_q, gap_d;
    logic [numNeurons*dataWidth-1:0] send_buf_q, send_buf_d;
    logic [dataWidth-1:0]            data_out_q, data_out_d;
    logic                            data_valid_q, data_valid_d;
    logic                            busy_q, busy_d;

    logic                            capture;
    logic                            full;
    logic [numNeurons*dataWidth-1:0] coll;

    result_collector #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth)
    ) u_collector (
        .clk            (clk),
        .rst            (rst),
        .neuron_out_i   (neuron_out),
        .neuron_valid_i (neuron_valid),
        .capture_i      (capture),
        .clr_err_i      (clr_err),
        .coll_o         (coll),
        .full_o         (full),
        .overrun_o      (overrun)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        send_buf_d   = send_buf_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full) begin
                    capture      = 1'b1;
                    send_buf_d   = coll;
                    data_out_d   = coll[dataWidth-1:0];
                    data_valid_d = 1'b1;
                    cnt_d        = CW'(1);
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    data_out_d   = send_buf_q[int'(cnt_q)*dataWidth +: dataWidth];
                    data_valid_d = 1'b1;
                    cnt_d        = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    // The send buffer is only read in SEND, after a capture has loaded it.
    always_ff @(posedge clk) begin
        send_buf_q <= send_buf_d;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule
